// File: rtl/div_ctrl.sv
// ============================================================================
// Module   : div_ctrl
// Brief    : Multi-cycle 32-bit radix-2 restoring divider controller for the
//            execute stage. Supports signed (DIV) and unsigned (DIVU)
//            operation, flush abort, and a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        div_valid,
  input  logic        div_signed,
  input  logic [31:0] div_src1,
  input  logic [31:0] div_src2,
  input  logic        flush,
  output logic        div_ready,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] div_quot,
  output logic [31:0] div_rem
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    SIGN = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [4:0] C_LAST_STEP = 5'd31;

  state_t      state_q;
  logic        ready_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] quot_q;
  logic [31:0] rem_q;

  // Request operands captured at accept
  logic [31:0] src1_q;
  logic [31:0] src2_q;
  logic        sgn_q;

  // Datapath: dvd_q starts as the dividend magnitude and is progressively
  // replaced by quotient bits shifted in at the LSB.
  logic [31:0] dvd_q;
  logic [31:0] dsr_q;
  logic [32:0] prem_q;
  logic [4:0]  cnt_q;
  logic        qneg_q;
  logic        rneg_q;

  // Next-state candidates from the combinational step logic
  logic [31:0] mag1_d;
  logic [31:0] mag2_d;
  logic [32:0] shl_rem;
  logic [32:0] trial;
  logic [32:0] prem_d;
  logic [31:0] dvd_d;
  logic [31:0] quot_d;
  logic [31:0] rem_d;

  // Operand magnitudes, one restoring step and the final sign fix-up
  always_comb begin
    mag1_d  = (sgn_q && src1_q[31]) ? (32'd0 - src1_q) : src1_q;
    mag2_d  = (sgn_q && src2_q[31]) ? (32'd0 - src2_q) : src2_q;
    shl_rem = {prem_q[31:0], dvd_q[31]};
    trial   = shl_rem - {1'b0, dsr_q};
    prem_d  = trial[32] ? shl_rem : trial;
    dvd_d   = {dvd_q[30:0], ~trial[32]};
    quot_d  = qneg_q ? (32'd0 - dvd_q) : dvd_q;
    rem_d   = rneg_q ? (32'd0 - prem_q[31:0]) : prem_q[31:0];
  end

  // Controller FSM with registered status outputs and result registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= 32'd0;
      rem_q   <= 32'd0;
      src1_q  <= 32'd0;
      src2_q  <= 32'd0;
      sgn_q   <= 1'b0;
      dvd_q   <= 32'd0;
      dsr_q   <= 32'd0;
      prem_q  <= 33'd0;
      cnt_q   <= 5'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else if (flush && (state_q != IDLE)) begin
      // Abort: results keep the previous operation's values
      state_q <= IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_valid && !flush) begin
            src1_q  <= div_src1;
            src2_q  <= div_src2;
            sgn_q   <= div_signed;
            state_q <= PREP;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        PREP: begin
          dvd_q   <= mag1_d;
          dsr_q   <= mag2_d;
          qneg_q  <= (src1_q[31] ^ src2_q[31]) & sgn_q;
          rneg_q  <= src1_q[31] & sgn_q;
          prem_q  <= 33'd0;
          cnt_q   <= C_LAST_STEP;
          state_q <= CALC;
        end
        CALC: begin
          dvd_q  <= dvd_d;
          prem_q <= prem_d;
          if (cnt_q == 5'd0) begin
            state_q <= SIGN;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        SIGN: begin
          quot_q  <= quot_d;
          rem_q   <= rem_d;
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign div_ready = ready_q;
  assign div_busy  = busy_q;
  assign div_done  = done_q;
  assign div_quot  = quot_q;
  assign div_rem   = rem_q;

endmodule

`default_nettype wire

// File: tb/tb_div_ctrl.sv
// ============================================================================
// Module   : tb_div_ctrl
// Brief    : Self-checking scoreboard bench for div_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_ctrl;

  logic        clk;
  logic        resetn;
  logic        div_valid;
  logic        div_signed;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        flush;
  logic        div_ready;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_quot;
  logic [31:0] div_rem;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          c;
  } exp_t;

  exp_t        sb[$];
  int          cyc;
  int          n_chk;
  int          n_pass;
  logic [31:0] last_q;
  logic [31:0] last_r;

  div_ctrl u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .div_valid (div_valid),
    .div_signed(div_signed),
    .div_src1  (div_src1),
    .div_src2  (div_src2),
    .flush     (flush),
    .div_ready (div_ready),
    .div_busy  (div_busy),
    .div_done  (div_done),
    .div_quot  (div_quot),
    .div_rem   (div_rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (obs === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference division from the architectural definition
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] am, bm, q, r;
    am = (s && a[31]) ? (32'd0 - a) : a;
    bm = (s && b[31]) ? (32'd0 - b) : b;
    if (bm == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = am;
    end else begin
      q = am / bm;
      r = am % bm;
    end
    if (s && (a[31] ^ b[31])) q = 32'd0 - q;
    if (s && a[31]) r = 32'd0 - r;
    return {q, r};
  endfunction

  // Monitor: pop and compare on every done pulse
  always @(negedge clk) begin
    if (div_done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(div_done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", {div_quot, div_rem}, {e.q, e.r});
        check("done_cycle", 64'(cyc), 64'(e.c));
        last_q = e.q;
        last_r = e.r;
      end
    end
  end

  // Caller is positioned #1 after a rising edge
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic psh, input logic [31:0] eq, input logic [31:0] er,
                          output int acc);
    int n;
    exp_t e;
    n = 0;
    while (!div_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", 64'(div_ready), 64'd1);
    div_valid  = 1'b1;
    div_src1   = a;
    div_src2   = b;
    div_signed = s;
    acc = cyc;
    if (psh) begin
      e.q = eq; e.r = er; e.c = acc + 35;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    div_valid = 1'b0;
    div_src1  = $urandom;
    div_src2  = $urandom;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  // Abort an operation with flush during cycle k of it
  task automatic flush_at(input int k);
    int acc;
    start_op(32'd50, 32'd5, 1'b0, 1'b0, 32'd0, 32'd0, acc);
    wait_until(acc + k);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_status", {61'd0, div_ready, div_busy, div_done}, 64'b100);
    check("flush_hold", {div_quot, div_rem}, {last_q, last_r});
  endtask

  initial begin
    int acc, acc2, n;
    logic [31:0] a, b;
    logic s;
    logic [63:0] m;

    n_chk = 0; n_pass = 0;
    last_q = 32'd0; last_r = 32'd0;
    resetn = 1'b0; div_valid = 1'b0; div_signed = 1'b0;
    div_src1 = 32'd0; div_src2 = 32'd0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_status", {61'd0, div_ready, div_busy, div_done}, 64'b100);
    check("reset_result", {div_quot, div_rem}, 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // 100/7 with busy window and latency
    start_op(32'd100, 32'd7, 1'b0, 1'b1, 32'h0000_000E, 32'h0000_0002, acc);
    for (int i = 1; i <= 34; i++) begin
      check("busy_window", {62'd0, div_ready, div_busy}, 64'b01);
      @(posedge clk); #1;
    end
    check("done_status", {62'd0, div_ready, div_busy}, 64'b00);
    @(posedge clk); #1;
    check("ready_after", 64'(div_ready), 64'd1);

    // Directed signed and boundary cases
    start_op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, acc);
    start_op(32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'h0000_0001, acc);
    start_op(32'd5, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0005, acc);
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0000, acc);
    start_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, acc);

    // Random mix through the reference model
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 100)) : $urandom;
      if (i % 3 == 0) b = 32'd0 - b;
      s = 1'($urandom_range(0, 1));
      m = model(a, b, s);
      start_op(a, b, s, 1'b1, m[63:32], m[31:0], acc);
    end

    // Flush at cycle 10, re-accept 9/3 at cycle 11
    wait_until(cyc + 40);
    start_op(32'd50, 32'd5, 1'b0, 1'b0, 32'd0, 32'd0, acc);
    wait_until(acc + 10);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_status", {61'd0, div_ready, div_busy, div_done}, 64'b100);
    check("flush_hold", {div_quot, div_rem}, {last_q, last_r});
    start_op(32'd9, 32'd3, 1'b0, 1'b1, 32'd3, 32'd0, acc2);
    check("flush_reaccept", 64'(acc2), 64'(acc + 11));
    wait_until(acc2 + 40);

    // Flush during SIGN must not disturb the held result
    flush_at(34);

    // flush beats a request in IDLE
    div_valid = 1'b1; flush = 1'b1;
    div_src1 = 32'd8; div_src2 = 32'd2; div_signed = 1'b0;
    @(posedge clk); #1;
    div_valid = 1'b0; flush = 1'b0;
    check("idle_flush", {62'd0, div_ready, div_busy}, 64'b10);

    // Reset mid-flight with a request held during reset
    start_op(32'd1000, 32'd3, 1'b0, 1'b0, 32'd0, 32'd0, acc);
    wait_until(acc + 20);
    resetn = 1'b0;
    div_valid = 1'b1; div_src1 = 32'd9; div_src2 = 32'd3; div_signed = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_status", {61'd0, div_ready, div_busy, div_done}, 64'b100);
      check("rst_result", {div_quot, div_rem}, 64'd0);
    end
    last_q = 32'd0; last_r = 32'd0;
    resetn = 1'b1;
    begin
      exp_t e;
      e.q = 32'd3; e.r = 32'd0; e.c = cyc + 35;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    div_valid = 1'b0;
    check("rst_accept", {62'd0, div_ready, div_busy}, 64'b01);
    wait_until(cyc + 40);

    // Back-to-back with div_valid held high; operands change while busy
    begin
      exp_t e;
      div_valid = 1'b1; div_signed = 1'b0;
      div_src1 = 32'd77; div_src2 = 32'd10;
      acc = cyc;
      e.q = 32'd7; e.r = 32'd7; e.c = acc + 35;
      sb.push_back(e);
      @(posedge clk); #1;
      div_src1 = 32'hFFFF_FFEC; div_src2 = 32'd3; div_signed = 1'b1;
      m = model(32'hFFFF_FFEC, 32'd3, 1'b1);
      e.q = m[63:32]; e.r = m[31:0]; e.c = acc + 71;
      sb.push_back(e);
      wait_until(acc + 36);
      check("b2b_ready", 64'(div_ready), 64'd1);
      @(posedge clk); #1;
      div_valid = 1'b0;
    end

    // Drain the scoreboard
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
